// File: rtl/aes_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | aes_pkg : shared AES key-schedule types, Nk/Nr lookups, Rcon table |
// | Macro   : AES_KS_REVERSE_EN adds the DRAIN state                   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package aes_pkg;

    localparam int RK_WIDTH = 128;

    localparam logic [1:0] c_ks_128 = 2'd0;
    localparam logic [1:0] c_ks_192 = 2'd1;
    localparam logic [1:0] c_ks_256 = 2'd2;
    localparam logic [1:0] c_ks_bad = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
`ifdef AES_KS_REVERSE_EN
        ST_DRAIN = 2'd2,
`endif
        ST_GEN   = 2'd1
    } ks_state_t;

    function automatic logic [3:0] nk_of(input logic [1:0] ks);
        case (ks)
            c_ks_192: return 4'd6;
            c_ks_256: return 4'd8;
            default:  return 4'd4;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] ks);
        case (ks)
            c_ks_192: return 4'd12;
            c_ks_256: return 4'd14;
            default:  return 4'd10;
        endcase
    endfunction

    // n = (i / Nk) - 1
    function automatic logic [7:0] rcon(input logic [3:0] n);
        case (n)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | S_box : AES forward S-box, one byte, combinational lookup          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module S_box (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    localparam logic [0:255][7:0] c_sbox = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign out_byte = c_sbox[in_byte];
endmodule
`default_nettype wire

// File: rtl/aes_sub_word.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | aes_sub_word : SubWord, four S-boxes across a 32-bit word          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module aes_sub_word (
    input  logic [31:0] word_in,
    output logic [31:0] word_out
);
    for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
        S_box u_sbox (
            .in_byte  (word_in[8*gi +: 8]),
            .out_byte (word_out[8*gi +: 8])
        );
    end
endmodule
`default_nettype wire

// File: rtl/aes_key_expander.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | aes_key_expander : AES-128/192/256 key schedule, one word/cycle,   |
// |                    round keys over a valid/ready handshake         |
// | Macro            : AES_KS_REVERSE_EN (round-key store, Nr..0 order)|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module aes_key_expander #(
    parameter int KEY_MAX  = 256,
    parameter int RK_WIDTH = aes_pkg::RK_WIDTH
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                Start,
    input  logic [1:0]          Key_Size,
    input  logic [KEY_MAX-1:0]  M_KEY,
    input  logic                Reverse,
    output logic                Busy,
    output logic                RK_Valid,
    input  logic                RK_Ready,
    output logic [RK_WIDTH-1:0] RK_Data,
    output logic [3:0]          RK_Index,
    output logic                Done
);
    import aes_pkg::*;

    ks_state_t    r_state, w_state_nxt;
    logic [31:0]  r_win [0:7];
    logic [31:0]  w_mkw [0:7];
    logic [31:0]  w_load [0:7];
    logic [255:0] w_mk;
    logic [5:0]   r_i, w_total;
    logic [2:0]   r_mod;
    logic [3:0]   r_rc, r_nk, r_nr, r_kidx, w_nk_in;
    logic [95:0]  r_part;
    logic [1:0]   r_pcnt;
    logic [127:0] r_stg, w_key;
    logic         r_stg_v;
    logic [31:0]  w_prev, w_back, w_sub_in, w_sub_out, w_temp, w_new;
    logic         w_rev, w_rev_in, w_accept, w_ks_ok, w_hs, w_gen_en;
    logic         w_key_done, w_last_word, w_fwd_key, w_done_nxt;

`ifdef AES_KS_REVERSE_EN
    logic         r_rev;
    logic [127:0] r_store [0:14];
    assign w_rev    = r_rev;
    assign w_rev_in = Reverse;
`else
    assign w_rev    = 1'b0;
    assign w_rev_in = 1'b0;
`endif

    assign w_mk     = 256'(M_KEY) << (256 - KEY_MAX);
    assign w_nk_in  = nk_of(Key_Size);
    assign w_ks_ok  = (Key_Size == c_ks_128) ||
                      (Key_Size == c_ks_192 && KEY_MAX >= 192) ||
                      (Key_Size == c_ks_256 && KEY_MAX >= 256);
    assign w_accept = (r_state == ST_IDLE) && Start && w_ks_ok;
    assign Busy     = (r_state != ST_IDLE);
    assign w_hs     = RK_Valid && RK_Ready;
    assign w_total  = {r_nr, 2'b00} + 6'd4;

    // Window slot 0 holds w[i-1], slot k holds w[i-1-k]
    always_comb begin
        for (int j = 0; j < 8; j++) begin
            w_mkw[j]  = w_mk[255 - 32*j -: 32];
        end
        for (int k = 0; k < 8; k++) begin
            w_load[k] = (4'(k) < w_nk_in) ? w_mkw[3'(w_nk_in - 4'(k) - 4'd1)] : 32'h0;
        end
    end

    assign w_prev   = r_win[0];
    assign w_back   = r_win[3'(r_nk - 4'd1)];
    assign w_sub_in = (r_mod == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

    aes_sub_word u_sub_word (
        .word_in  (w_sub_in),
        .word_out (w_sub_out)
    );

    always_comb begin
        w_temp = w_prev;
        if (r_mod == 3'd0)
            w_temp = w_sub_out ^ {rcon(r_rc), 24'h0};
        else if (r_nk == 4'd8 && r_mod == 3'd4)
            w_temp = w_sub_out;
    end

    assign w_new       = w_back ^ w_temp;
    assign w_key       = {r_part, w_new};
    // Freeze only when the staged slot is full and nothing drains into the presented slot
    assign w_gen_en    = (r_state == ST_GEN) && (r_i != w_total) && (w_rev || !r_stg_v || w_hs);
    assign w_key_done  = w_gen_en && (r_pcnt == 2'd3);
    assign w_last_word = w_gen_en && (r_i == w_total - 6'd1);
    assign w_fwd_key   = w_key_done && !w_rev;

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = ST_GEN;
            ST_GEN: begin
                if (!w_rev && w_hs && RK_Index == r_nr) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end
`ifdef AES_KS_REVERSE_EN
                if (w_rev && w_last_word) w_state_nxt = ST_DRAIN;
`endif
            end
`ifdef AES_KS_REVERSE_EN
            ST_DRAIN: if (w_hs && RK_Index == 4'd0) begin
                w_state_nxt = ST_IDLE;
                w_done_nxt  = 1'b1;
            end
`endif
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int k = 0; k < 8; k++) r_win[k] <= 32'h0;
            r_i <= '0; r_mod <= '0; r_rc <= '0; r_nk <= 4'd4; r_nr <= 4'd10;
            r_kidx <= '0; r_part <= '0; r_pcnt <= '0; r_stg <= '0; r_stg_v <= 1'b0;
            RK_Valid <= 1'b0; RK_Data <= '0; RK_Index <= '0; Done <= 1'b0;
        end else begin
            Done <= w_done_nxt;
            if (w_accept) begin
                for (int k = 0; k < 8; k++) r_win[k] <= w_load[k];
                r_i      <= 6'(w_nk_in);
                r_mod    <= 3'd0;
                r_rc     <= 4'd0;
                r_nk     <= w_nk_in;
                r_nr     <= nr_of(Key_Size);
                RK_Valid <= !w_rev_in;
                RK_Data  <= w_mk[255:128];
                RK_Index <= 4'd0;
                r_part   <= {32'h0, w_mkw[4], w_mkw[5]};
                r_pcnt   <= (w_nk_in == 4'd6) ? 2'd2 : 2'd0;
                r_kidx   <= (w_nk_in == 4'd8) ? 4'd2 : 4'd1;
                r_stg    <= w_mk[127:0];
                r_stg_v  <= (w_nk_in == 4'd8) && !w_rev_in;
            end else begin
                if (w_gen_en) begin
                    r_win[0] <= w_new;
                    for (int k = 1; k < 8; k++) r_win[k] <= r_win[k-1];
                    r_i    <= r_i + 6'd1;
                    r_part <= {r_part[63:0], w_new};
                    r_pcnt <= r_pcnt + 2'd1;
                    if (r_mod == 3'(r_nk - 4'd1)) begin
                        r_mod <= 3'd0;
                        r_rc  <= r_rc + 4'd1;
                    end else begin
                        r_mod <= r_mod + 3'd1;
                    end
                    if (w_key_done) r_kidx <= r_kidx + 4'd1;
                end
`ifdef AES_KS_REVERSE_EN
                if (w_rev) begin
                    if (w_last_word) begin
                        RK_Valid <= 1'b1;
                        RK_Data  <= w_key;
                        RK_Index <= r_kidx;
                    end else if (w_hs) begin
                        if (RK_Index == 4'd0) begin
                            RK_Valid <= 1'b0;
                        end else begin
                            RK_Data  <= r_store[RK_Index - 4'd1];
                            RK_Index <= RK_Index - 4'd1;
                        end
                    end
                end else
`endif
                if (!RK_Valid || w_hs) begin
                    if (r_stg_v) begin
                        RK_Valid <= 1'b1;
                        RK_Data  <= r_stg;
                        RK_Index <= RK_Index + 4'd1;
                        r_stg    <= w_key;
                        r_stg_v  <= w_fwd_key;
                    end else if (w_fwd_key) begin
                        RK_Valid <= 1'b1;
                        RK_Data  <= w_key;
                        RK_Index <= r_kidx;
                    end else begin
                        RK_Valid <= 1'b0;
                    end
                end else if (w_fwd_key) begin
                    r_stg   <= w_key;
                    r_stg_v <= 1'b1;
                end
            end
        end
    end

`ifdef AES_KS_REVERSE_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_rev <= 1'b0;
            for (int k = 0; k < 15; k++) r_store[k] <= '0;
        end else if (w_accept) begin
            r_rev      <= Reverse;
            r_store[0] <= w_mk[255:128];
            if (w_nk_in == 4'd8) r_store[1] <= w_mk[127:0];
        end else if (w_key_done) begin
            r_store[r_kidx] <= w_key;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_aes_key_expander.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_aes_key_expander : directed FIPS-197 vectors for the key expander|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_aes_key_expander;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         Start = 1'b0;
    logic [1:0]   Key_Size = 2'd0;
    logic [255:0] M_KEY = '0;
    logic         Reverse = 1'b0;
    logic         RK_Ready = 1'b1;
    logic         Busy, RK_Valid, Done;
    logic [127:0] RK_Data;
    logic [3:0]   RK_Index;

    aes_key_expander #(.KEY_MAX(256), .RK_WIDTH(128)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .Start    (Start),
        .Key_Size (Key_Size),
        .M_KEY    (M_KEY),
        .Reverse  (Reverse),
        .Busy     (Busy),
        .RK_Valid (RK_Valid),
        .RK_Ready (RK_Ready),
        .RK_Data  (RK_Data),
        .RK_Index (RK_Index),
        .Done     (Done)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc++;

    localparam logic [255:0] c_k128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] c_k192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] c_k256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] c_rk1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] c_rk2  = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] c_rk10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] c_r256 = 128'hfe4890d1e6188d0b046df344706c631e;

    int n_vec = 0;
    int n_fail = 0;
    logic [127:0] rk_got [0:14];
    int rk_time [0:14];
    int last_idx, done_t, n_keys, t0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [1:0] ks, input logic [255:0] key, input logic rev, output int t_acc);
        Start = 1'b1; Key_Size = ks; M_KEY = key; Reverse = rev;
        @(posedge CLK); #1;
        Start = 1'b0;
        t_acc = cyc;
    endtask

    // Records every handshaked key by index; optional 20-cycle back-pressure on one index
    task automatic collect(input int t_acc, input int first_idx, input int step,
                           input int stall_idx, input logic [127:0] stall_exp, input int budget);
        int  exp_idx = first_idx;
        int  stall_left = 20;
        bit  fin = 1'b0;
        done_t = -1; n_keys = 0; last_idx = -1;
        for (int k = 0; k < 15; k++) begin rk_got[k] = '0; rk_time[k] = -1; end
        for (int n = 0; n < budget && !fin; n++) begin
            if (RK_Valid && RK_Index == stall_idx && stall_left > 0) begin
                RK_Ready = 1'b0;
                chk("stall_hold", RK_Data, stall_exp);
                stall_left--;
            end else begin
                RK_Ready = 1'b1;
            end
            if (RK_Valid && RK_Ready) begin
                chk("rk_index_seq", 128'(RK_Index), 128'(exp_idx));
                rk_got[RK_Index]  = RK_Data;
                rk_time[RK_Index] = cyc - t_acc;
                last_idx = int'(RK_Index);
                n_keys++;
                exp_idx += step;
            end
            if (Done) begin
                done_t = cyc - t_acc;
                fin = 1'b1;
            end else begin
                @(posedge CLK); #1;
            end
        end
        n_vec++;
        assert (fin) else begin
            n_fail++;
            $error("FAIL done_timeout: observed no Done within %0d cycles", budget);
        end
        RK_Ready = 1'b1;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_busy",  128'(Busy), 128'(0));
        chk("rst_valid", 128'(RK_Valid), 128'(0));
        chk("rst_data",  RK_Data, 128'h0);
        chk("rst_index", 128'(RK_Index), 128'(0));
        chk("rst_done",  128'(Done), 128'(0));
        RST = 1'b1;
        @(posedge CLK); #1;

        // AES-128 forward, Ready high
        start_op(2'd0, c_k128, 1'b0, t0);
        chk("a128_busy",  128'(Busy), 128'(1));
        chk("a128_valid", 128'(RK_Valid), 128'(1));
        collect(t0, 0, 1, -1, 128'h0, 200);
        chk("a128_rk0",    rk_got[0], c_k128[255:128]);
        chk("a128_rk1",    rk_got[1], c_rk1);
        chk("a128_rk2",    rk_got[2], c_rk2);
        chk("a128_rk10",   rk_got[10], c_rk10);
        chk("a128_t_rk1",  128'(rk_time[1]), 128'(4));
        chk("a128_t_rk10", 128'(rk_time[10]), 128'(40));
        chk("a128_t_done", 128'(done_t), 128'(41));
        chk("a128_nkeys",  128'(n_keys), 128'(11));
        @(posedge CLK); #1;
        chk("a128_idle",   128'(Busy), 128'(0));
        chk("a128_done_pulse", 128'(Done), 128'(0));

        // AES-192 forward
        start_op(2'd1, c_k192, 1'b0, t0);
        collect(t0, 0, 1, -1, 128'h0, 250);
        chk("a192_w6",    128'(rk_got[1][63:32]), 128'(32'hfe0c91f7));
        chk("a192_w51",   128'(rk_got[12][31:0]), 128'(32'h01002202));
        chk("a192_last",  128'(last_idx), 128'(12));
        chk("a192_nkeys", 128'(n_keys), 128'(13));
        @(posedge CLK); #1;

        // AES-256 forward
        start_op(2'd2, c_k256, 1'b0, t0);
        collect(t0, 0, 1, -1, 128'h0, 250);
        chk("a256_rk0",    rk_got[0], c_k256[255:128]);
        chk("a256_rk1",    rk_got[1], c_k256[127:0]);
        chk("a256_w8",     128'(rk_got[2][127:96]), 128'(32'h9ba35411));
        chk("a256_rk14",   rk_got[14], c_r256);
        chk("a256_t_rk1",  128'(rk_time[1]), 128'(1));
        chk("a256_t_rk2",  128'(rk_time[2]), 128'(4));
        chk("a256_t_rk14", 128'(rk_time[14]), 128'(52));
        @(posedge CLK); #1;

        // AES-128 with 20 cycles of back-pressure on RK_2
        start_op(2'd0, c_k128, 1'b0, t0);
        collect(t0, 0, 1, 2, c_rk2, 300);
        chk("stall_rk1",   rk_got[1], c_rk1);
        chk("stall_rk2",   rk_got[2], c_rk2);
        chk("stall_rk10",  rk_got[10], c_rk10);
        chk("stall_nkeys", 128'(n_keys), 128'(11));
        @(posedge CLK); #1;

        // Illegal key size is ignored
        start_op(2'd3, c_k256, 1'b0, t0);
        chk("bad_ks_busy",  128'(Busy), 128'(0));
        chk("bad_ks_valid", 128'(RK_Valid), 128'(0));
        @(posedge CLK); #1;
        chk("bad_ks_busy2", 128'(Busy), 128'(0));

        // Start while busy is ignored
        RK_Ready = 1'b0;
        start_op(2'd0, c_k128, 1'b0, t0);
        Start = 1'b1; Key_Size = 2'd2; M_KEY = c_k256;
        @(posedge CLK); #1;
        Start = 1'b0;
        chk("busy_start_data", RK_Data, c_k128[255:128]);
        collect(t0, 0, 1, -1, 128'h0, 250);
        chk("busy_start_rk10",  rk_got[10], c_rk10);
        chk("busy_start_nkeys", 128'(n_keys), 128'(11));
        @(posedge CLK); #1;

        // Reset in the middle of generation
        start_op(2'd0, c_k128, 1'b0, t0);
        repeat (10) @(posedge CLK);
        #1;
        RST = 1'b0;
        #1;
        chk("mid_rst_busy",  128'(Busy), 128'(0));
        chk("mid_rst_valid", 128'(RK_Valid), 128'(0));
        chk("mid_rst_data",  RK_Data, 128'h0);
        chk("mid_rst_index", 128'(RK_Index), 128'(0));
        for (int n = 0; n < 3; n++) begin
            @(posedge CLK); #1;
            chk("mid_rst_no_done", 128'(Done), 128'(0));
        end
        RST = 1'b1;
        @(posedge CLK); #1;
        chk("post_rst_busy", 128'(Busy), 128'(0));
        chk("post_rst_done", 128'(Done), 128'(0));

`ifdef AES_KS_REVERSE_EN
        // Decryption order playback
        start_op(2'd0, c_k128, 1'b1, t0);
        collect(t0, 10, -1, -1, 128'h0, 250);
        chk("rev_rk10",    rk_got[10], c_rk10);
        chk("rev_rk1",     rk_got[1], c_rk1);
        chk("rev_rk0",     rk_got[0], c_k128[255:128]);
        chk("rev_t_first", 128'(rk_time[10]), 128'(40));
        chk("rev_last",    128'(last_idx), 128'(0));
        chk("rev_nkeys",   128'(n_keys), 128'(11));
`else
        // Reverse is ignored without the store: order stays forward
        start_op(2'd0, c_k128, 1'b1, t0);
        collect(t0, 0, 1, -1, 128'h0, 250);
        chk("norev_rk10",  rk_got[10], c_rk10);
        chk("norev_last",  128'(last_idx), 128'(10));
        chk("norev_nkeys", 128'(n_keys), 128'(11));
`endif

        @(posedge CLK); #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
